bothmult: RTL and testbench
===========================

BOTHMULT -- requirements
Module: bothmult

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, synchronous and active-low.
REQ-003 SHALL have port inbus, input, 6 bits: two's-complement operand bus, carrying multiplicand A, then multiplier B.
REQ-004 SHALL have port start, input, 1 bit: operation request, level-sampled on the rising edge.
REQ-005 SHALL have port outbus, output, 6 bits: product halves, serialized.
REQ-006 SHALL have port ready, output, 1 bit: high while outbus carries a valid product half.
REQ-007 SHALL use positional port order (inbus, start, clk, rst, outbus, ready).

Function
REQ-008 SHALL implement a radix-2 Booth signed multiplier, 6x6 -> 12-bit two's-complement product.
REQ-009 SHALL use FSM states IDLE, WAIT_LOW, DELAY, LOAD_B, CALC, OUT_LO, OUT_HI.
REQ-010 IDLE: at an edge with start=1, SHALL capture inbus as A and go to WAIT_LOW; otherwise it stays in IDLE.
REQ-011 WAIT_LOW: SHALL stay while start=1; at the first edge with start=0 it goes to DELAY with the delay count cleared.
REQ-012 DELAY: SHALL count 2 edges, then go to LOAD_B; B SHALL be captured from inbus at the 4th edge counted from the edge that first sampled start=0.
REQ-013 The B-capture edge SHALL initialise P = {7'b0, B, 1'b0} with the iteration count at 0, then enter CALC.
REQ-014 CALC: SHALL do exactly 6 iterations, one per edge.
REQ-015 Each CALC iteration SHALL act on P's LSB pair: 10 -> upper -= A; 01 -> upper += A; 00/11 -> no add; then arithmetic shift right by 1.
REQ-016 The upper part SHALL be a 7-bit sign-extended accumulator, so A=-32 gives exact results (-32*-32 = +1024).
REQ-017 After the 6th iteration SHALL go to OUT_LO; latency from B capture to ready high = 7 edges.
REQ-018 OUT_LO: SHALL drive outbus = product[5:0] with ready=1 for one cycle, then go to OUT_HI.
REQ-019 OUT_HI: SHALL drive outbus = product[11:6] with ready=1 for one cycle, then go to IDLE.
REQ-020 Outputs SHALL be Moore-decoded from registered state; in every state other than OUT_LO/OUT_HI, ready=0 and outbus=0.
REQ-021 start SHALL be ignored in every state except IDLE and WAIT_LOW; there is no abort.
REQ-022 inbus SHALL be don't-care except at the A-capture and B-capture edges.
REQ-023 Back-to-back operation: start=1 at the edge ending OUT_HI SHALL be ignored; start is honoured from IDLE on the next edge.

Reset
REQ-024 At any edge with rst=0 the block SHALL go to IDLE and clear A, P and all counters, with ready=0 and outbus=0.
REQ-025 Reset SHALL take priority over start, including in the middle of an operation; the partial result is discarded.
REQ-026 After rst returns to 1, the first accepted start SHALL begin a clean operation.

Configuration
REQ-027 Macro BOTHMULT_HIGH_FIRST_EN, when defined, SHALL swap the output order: OUT_HI (product[11:6]) comes first, then product[5:0].
REQ-028 Without BOTHMULT_HIGH_FIRST_EN, the order SHALL be the low half first (default).
REQ-029 Latency, ready timing and all other behaviour SHALL be identical in both builds.

Verification
REQ-030 Reset low 2 cycles, then A=21 (010101), start high 2 edges, B=9 (001001) at the 4th edge after start low -> ready 2 cycles, outbus 111101 then 000010 (+189).
REQ-031 A=-7 (111001), B=10 (001010) -> outbus 111010 then 111110 (-70 = 111110111010).
REQ-032 A=5 (000101), B=-8 (111000) -> outbus 011000 then 111111 (-40).
REQ-033 A=-13 (110011), B=-22 (101010) -> outbus 011110 then 000100 (+286); also A=B=-32 -> +1024 (000000, 010000).
REQ-034 rst=0 asserted during CALC -> next edge ready=0, outbus=0, IDLE; a subsequent 21x9 run SHALL again yield 189.
REQ-035 start pulsed during CALC/OUT states -> ignored, no change in result or timing; with BOTHMULT_HIGH_FIRST_EN, 21x9 -> 000010 then 111101.

Source files
------------

// File: rtl/bothmult.sv
// bothmult: 6x6 radix-2 Booth signed multiplier with a serialized 12-bit product.
// Operands A then B arrive on inbus under a start handshake.
// The product leaves as two 6-bit halves on outbus while ready is high.
// Optional macro BOTHMULT_HIGH_FIRST_EN sends product[11:6] before product[5:0].
module bothmult (
  input  logic [5:0] inbus,
  input  logic       start,
  input  logic       clk,
  input  logic       rst,
  output logic [5:0] outbus,
  output logic       ready
);

  localparam int unsigned W       = 6;
  localparam int unsigned ACC_W   = W + 1;          // sign-extended accumulator
  localparam int unsigned P_W     = ACC_W + W + 1;  // {acc, multiplier, booth bit}
  localparam int unsigned DLY_CYC = 2;
  localparam int unsigned ITERS   = W;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_LOW,
    DELAY,
    LOAD_B,
    CALC,
    OUT_LO,
    OUT_HI
  } state_t;

  state_t             state_q, state_d;
  logic [W-1:0]       a_q, a_d;
  logic [P_W-1:0]     p_q, p_d;
  logic [1:0]         dly_q, dly_d;
  logic [2:0]         iter_q, iter_d;
  logic [W-1:0]       outbus_q, outbus_d;
  logic               ready_q, ready_d;

  logic [ACC_W-1:0]   acc;
  logic [ACC_W-1:0]   a_ext;
  logic [ACC_W-1:0]   sum;
  logic [P_W-1:0]     p_shift;
  logic [2*W-1:0]     product;

  // Booth step: add/subtract A into the upper part, then arithmetic shift right.
  always_comb begin
    acc   = p_q[P_W-1 -: ACC_W];
    a_ext = {a_q[W-1], a_q};
    sum   = acc;
    case (p_q[1:0])
      2'b10:   sum = acc - a_ext;
      2'b01:   sum = acc + a_ext;
      default: sum = acc;
    endcase
    p_shift = {sum[ACC_W-1], sum, p_q[W:1]};
    product = p_q[2*W:1];
  end

  // Next-state, datapath and registered-output decode.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    p_d      = p_q;
    dly_d    = dly_q;
    iter_d   = iter_q;
    ready_d  = 1'b0;
    outbus_d = '0;

    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = inbus;
          state_d = WAIT_LOW;
        end
      end
      WAIT_LOW: begin
        if (!start) begin
          dly_d   = '0;
          state_d = DELAY;
        end
      end
      DELAY: begin
        dly_d = dly_q + 2'd1;
        if (dly_q == 2'(DLY_CYC - 1)) begin
          state_d = LOAD_B;
        end
      end
      LOAD_B: begin
        p_d     = {ACC_W'(0), inbus, 1'b0};
        iter_d  = '0;
        state_d = CALC;
      end
      CALC: begin
        p_d    = p_shift;
        iter_d = iter_q + 3'd1;
        if (iter_q == 3'(ITERS - 1)) begin
`ifdef BOTHMULT_HIGH_FIRST_EN
          state_d = OUT_HI;
`else
          state_d = OUT_LO;
`endif
        end
      end
      OUT_LO: begin
        ready_d  = 1'b1;
        outbus_d = product[W-1:0];
`ifdef BOTHMULT_HIGH_FIRST_EN
        state_d  = IDLE;
`else
        state_d  = OUT_HI;
`endif
      end
      OUT_HI: begin
        ready_d  = 1'b1;
        outbus_d = product[2*W-1:W];
`ifdef BOTHMULT_HIGH_FIRST_EN
        state_d  = OUT_LO;
`else
        state_d  = IDLE;
`endif
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      a_q      <= '0;
      p_q      <= '0;
      dly_q    <= '0;
      iter_q   <= '0;
      outbus_q <= '0;
      ready_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      p_q      <= p_d;
      dly_q    <= dly_d;
      iter_q   <= iter_d;
      outbus_q <= outbus_d;
      ready_q  <= ready_d;
    end
  end

  assign outbus = outbus_q;
  assign ready  = ready_q;

endmodule

// File: tb/tb_bothmult.sv
// Directed bench for bothmult: fixed-timing operand handshake, product halves
// checked against hand-computed constants, plus mid-operation reset and
// ignored start pulses.
module tb_bothmult;

  logic       clk;
  logic       rst;
  logic       start;
  logic [5:0] inbus;
  logic [5:0] outbus;
  logic       ready;

  int total;
  int bad;

  bothmult dut (
    .inbus  (inbus),
    .start  (start),
    .clk    (clk),
    .rst    (rst),
    .outbus (outbus),
    .ready  (ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [5:0] got, input logic [5:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%b exp=%b", tag, got, exp);
    end
  endtask

  // Advance one edge; inputs change and outputs are sampled 1ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full operation; lo/hi are the expected product halves.
  // poke drives start during CALC and the output window.
  task automatic run_op(input string tag, input logic [5:0] a, input logic [5:0] b,
                        input logic [5:0] lo, input logic [5:0] hi, input bit poke);
    logic [5:0] first;
    logic [5:0] second;
`ifdef BOTHMULT_HIGH_FIRST_EN
    first  = hi;
    second = lo;
`else
    first  = lo;
    second = hi;
`endif
    start = 1'b1; inbus = a;
    tick();                                 // A captured
    inbus = 6'($urandom);
    tick();                                 // start still high in WAIT_LOW
    start = 1'b0;
    tick();                                 // E1: first start=0
    tick();                                 // E2
    tick();                                 // E3
    inbus = b;
    tick();                                 // E4: B captured
    inbus = 6'($urandom);
    for (int e = 5; e <= 10; e++) begin
      tick();
      if (poke && e == 6) start = 1'b1;
      if (poke && e == 8) start = 1'b0;
      if (poke && e == 10) start = 1'b1;
      if (e == 10) chk({tag, "_rdy_early"}, 6'(ready), 6'd0);
    end
    tick();                                 // E11
    chk({tag, "_rdy1"}, 6'(ready), 6'd1);
    chk({tag, "_first"}, outbus, first);
    tick();                                 // E12
    start = 1'b0;
    chk({tag, "_rdy2"}, 6'(ready), 6'd1);
    chk({tag, "_second"}, outbus, second);
    tick();                                 // E13
    chk({tag, "_rdy_end"}, 6'(ready), 6'd0);
    chk({tag, "_out_end"}, outbus, 6'd0);
  endtask

  // Start an operation and assert reset after stop_edge edges past start low.
  task automatic run_reset(input string tag, input int stop_edge, input logic [5:0] b);
    start = 1'b1; inbus = 6'd21;
    tick();
    tick();
    start = 1'b0;
    for (int e = 1; e <= stop_edge; e++) begin
      if (e == 4) inbus = b;
      tick();
      if (e == 4) inbus = 6'($urandom);
    end
    rst = 1'b0;
    start = 1'b1;                           // reset must win over start
    tick();
    chk({tag, "_rst_rdy"}, 6'(ready), 6'd0);
    chk({tag, "_rst_out"}, outbus, 6'd0);
    start = 1'b0;
    rst = 1'b1;
    tick();
    chk({tag, "_post_rdy"}, 6'(ready), 6'd0);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b0;
    start = 1'b0;
    inbus = 6'd0;
    tick();
    tick();
    chk("reset_rdy", 6'(ready), 6'd0);
    chk("reset_out", outbus, 6'd0);
    rst = 1'b1;
    tick();

    run_op("p21x9",   6'b010101, 6'b001001, 6'b111101, 6'b000010, 1'b0);
    run_op("m7x10",   6'b111001, 6'b001010, 6'b111010, 6'b111110, 1'b0);
    run_op("p5xm8",   6'b000101, 6'b111000, 6'b011000, 6'b111111, 1'b0);
    run_op("m13xm22", 6'b110011, 6'b101010, 6'b011110, 6'b000100, 1'b0);
    run_op("m32xm32", 6'b100000, 6'b100000, 6'b000000, 6'b010000, 1'b0);
    run_op("m32xp31", 6'b100000, 6'b011111, 6'b100000, 6'b110000, 1'b0);

    // Reset in the middle of CALC, then a clean run.
    run_reset("rst_calc", 6, 6'b001001);
    run_op("after_rst_calc", 6'b010101, 6'b001001, 6'b111101, 6'b000010, 1'b0);

    // Reset while the first product half is on the bus.
    run_reset("rst_out", 11, 6'b001001);
    run_op("after_rst_out", 6'b010101, 6'b001001, 6'b111101, 6'b000010, 1'b0);

    // Start pulses during CALC and output states must not disturb anything.
    run_op("poke21x9", 6'b010101, 6'b001001, 6'b111101, 6'b000010, 1'b1);
    run_op("back2back", 6'b111001, 6'b001010, 6'b111010, 6'b111110, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
